// File: rtl/nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// nibble_serial_addsub
//   Multi-cycle WIDTH-bit add/subtract engine built around one 4-bit
//   ripple-carry slice. An accepted operation is processed one nibble per
//   clock, LSB nibble first, and the slice carry is registered between
//   nibbles. The result and its flags are registered and offered on a
//   valid/ready output handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand request
//   in_ready   out  idle and able to accept (low while in reset)
//   op_a       in   operand A  [WIDTH-1:0]
//   op_b       in   operand B  [WIDTH-1:0]
//   sub        in   0: A+B, 1: A-B (two's complement)
//   out_valid  out  result available
//   out_ready  in   consumer takes the result
//   result     out  sum / difference modulo 2^WIDTH
//   carry_out  out  final carry (subtract: 1 = no borrow)
//   overflow   out  signed overflow
//   zero       out  result == 0
// ---------------------------------------------------------------------------
module nibble_serial_addsub #(
  parameter int NIBBLES = 4,
  localparam int WIDTH  = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // Counter only needs to reach NIBBLES-1; keep at least one bit.
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic [CNT_W+1:0] base_s;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic [4:0]       slice_s;
  logic [WIDTH-1:0] res_next_s;

  // Ready is decoded from state, but forced low while reset is asserted.
  assign in_ready  = rst_n & (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

  // The single 4-bit ripple slice working on the nibble selected by cnt_q.
  always_comb begin
    base_s     = {cnt_q, 2'b00};
    a_nib_s    = a_q[base_s +: 4];
    b_nib_s    = bx_q[base_s +: 4];
    slice_s    = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, carry_q};
    res_next_s = result_q;
    res_next_s[base_s +: 4] = slice_s[3:0];
  end

  // Sequencer next-state logic.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    bx_d        = bx_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with sub.
          a_d      = op_a;
          bx_d     = op_b ^ {WIDTH{sub}};
          carry_d  = sub;
          cnt_d    = {CNT_W{1'b0}};
          result_d = {WIDTH{1'b0}};
          state_d  = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = res_next_s;
        carry_d  = slice_s[4];
        if (cnt_q == LAST_NIB) begin
          // Last nibble: the slice MSB is the word MSB, so flags come from here.
          carry_out_d = slice_s[4];
          overflow_d  = (a_nib_s[3] == b_nib_s[3]) & (slice_s[3] != a_nib_s[3]);
          zero_d      = (res_next_s == {WIDTH{1'b0}});
          out_valid_d = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= {WIDTH{1'b0}};
      bx_q        <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bx_q        <= bx_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_addsub
//   Directed bench for nibble_serial_addsub (NIBBLES=4). The driver pushes
//   hand-computed expectations into a queue at accept time; a monitor pops
//   and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_nibble_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_mis   = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   prev_acc = 0;
  logic prev_ov = 1'b0;

  nibble_serial_addsub #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Present an operation, wait (bounded) for acceptance, log the expectation.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [15:0] r, input logic c, input logic v, input logic z);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({r, c, v, z});
      @(posedge clk);
      #1;
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: latency on each out_valid rise, full compare on each handoff.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, 32'd4);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result",    {16'd0, result}, {16'd0, e.r});
          check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
          check("overflow",  {31'd0, overflow},  {31'd0, e.v});
          check("zero",      {31'd0, zero},      {31'd0, e.z});
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; op_a = 16'h0000; op_b = 16'h0000;
    sub = 1'b0; out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    {16'd0, result},    32'd0);
    check("rst_flags",     {29'd0, carry_out, overflow, zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back with in_valid held high and out_ready tied high
    send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    check("b2b_spacing", acc_cyc - prev_acc, 32'd6);
    send(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    check("b2b_spacing2", acc_cyc - prev_acc, 32'd6);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Back-pressure, and in_valid pulsed during RUN must be ignored
    out_ready = 1'b0;
    send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #3;
      check("bp_hold_result", {16'd0, result}, 32'h2201);
      check("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",    {31'd0, in_ready},  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    check("handoff_in_ready",  {31'd0, in_ready},  32'd1);
    check("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset during the second RUN nibble
    send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_result",    {16'd0, result},    32'd0);
    check("abort_in_ready",  {31'd0, in_ready},  32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
